piso_serializer: RTL and testbench

Multi-channel parallel-in/serial-out engine for the cube's LED driver chains. It accepts one frame of CHANNELS×WIDTH bits through a valid/ready handshake and holds it in a shadow buffer. It then shifts all channels out in lock-step with a generated serial clock, and pulses a latch strobe at the end of each frame. It sits between the frame/layer scheduler and the driver-board pins, and replaces the single-lane, externally sequenced shift register.

---
 rtl/piso_serializer_pkg.sv | 19 +
 rtl/piso_lane.sv | 38 +++
 rtl/piso_serializer.sv | 128 ++++++++++++
 tb/tb_piso_serializer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - shared state type, width helper and default parameters for piso_serializer
package piso_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_CHANNELS = 4;
    localparam int DEFAULT_DIV      = 2;

    // Counter width that never collapses to zero bits when the count range is 1.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/piso_lane.sv
// rtl/piso_lane.sv - one load/shift lane; PISO_SERIALIZER_LSB_FIRST_EN selects LSB-first shifting
module piso_lane
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser
);

    logic [WIDTH-1:0] shreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= load_data;
        end else if (shift) begin
`ifdef PISO_SERIALIZER_LSB_FIRST_EN
            shreg <= {1'b0, shreg[WIDTH-1:1]};
`else
            shreg <= {shreg[WIDTH-2:0], 1'b0};
`endif
        end
    end

    // Zero fill means the lane output is already 0 once all WIDTH bits have gone.
`ifdef PISO_SERIALIZER_LSB_FIRST_EN
    assign ser = shreg[0];
`else
    assign ser = shreg[WIDTH-1];
`endif

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - multi-lane PISO with shadow buffer, sclk and latch; bit order via PISO_SERIALIZER_LSB_FIRST_EN
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int CHANNELS = DEFAULT_CHANNELS,
    parameter int DIV      = DEFAULT_DIV
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [CHANNELS-1:0]       ser_out,
    output logic                      sclk,
    output logic                      latch,
    output logic                      busy
);

    localparam int DIV_W = clog2_min1(DIV);
    localparam int BIT_W = $clog2(WIDTH);

    state_t                    state, state_next;
    logic [DIV_W-1:0]          div_cnt, div_cnt_next;
    logic [BIT_W-1:0]          bit_cnt, bit_cnt_next;
    logic [CHANNELS*WIDTH-1:0] shadow;
    logic                      shadow_full, shadow_full_next;
    logic                      transfer, load, shift;
    logic                      div_wrap, last_bit;
    logic                      sclk_next, latch_next;

    assign transfer = in_valid && in_ready;
    assign div_wrap = (div_cnt == DIV_W'(DIV - 1));
    assign last_bit = (bit_cnt == BIT_W'(WIDTH - 1));

    always_comb begin
        state_next   = state;
        load         = 1'b0;
        shift        = 1'b0;
        sclk_next    = sclk;
        latch_next   = latch;
        bit_cnt_next = bit_cnt;
        div_cnt_next = div_wrap ? '0 : div_cnt + DIV_W'(1);
        case (state)
            IDLE: begin
                div_cnt_next = '0;
                if (shadow_full) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (div_wrap) begin
                    if (!sclk) begin
                        sclk_next = 1'b1;
                    end else begin
                        // Falling sclk edge: advance every lane to its next bit.
                        sclk_next = 1'b0;
                        shift     = 1'b1;
                        if (last_bit) begin
                            bit_cnt_next = '0;
                            latch_next   = 1'b1;
                            state_next   = LATCH;
                        end else begin
                            bit_cnt_next = bit_cnt + BIT_W'(1);
                        end
                    end
                end
            end
            LATCH: begin
                if (div_wrap) begin
                    latch_next = 1'b0;
                    if (shadow_full) begin
                        load       = 1'b1;
                        state_next = SHIFT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // transfer and load never coincide: a load needs a full shadow, which holds in_ready low.
        shadow_full_next = transfer ? 1'b1 : (load ? 1'b0 : shadow_full);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            shadow_full <= 1'b0;
            in_ready    <= 1'b0;
            sclk        <= 1'b0;
            latch       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            div_cnt     <= div_cnt_next;
            bit_cnt     <= bit_cnt_next;
            shadow_full <= shadow_full_next;
            in_ready    <= !shadow_full_next;
            sclk        <= sclk_next;
            latch       <= latch_next;
            busy        <= (state_next != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && transfer) begin
            shadow <= in_data;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        piso_lane #(
            .WIDTH(WIDTH)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .load     (load),
            .shift    (shift),
            .load_data(shadow[c*WIDTH +: WIDTH]),
            .ser      (ser_out[c])
        );
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer (main and DIV=1/WIDTH=2 instances)
module tb_piso_serializer;

    localparam int W = 8;
    localparam int C = 2;
    localparam int D = 2;
    localparam int P = (2*W + 1) * D;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [C*W-1:0] in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [C-1:0]   ser_out;
    logic           sclk, latch, busy;

    logic [1:0]     c_in_data = '0;
    logic           c_in_valid = 1'b0;
    logic           c_in_ready;
    logic [0:0]     c_ser_out;
    logic           c_sclk, c_latch, c_busy;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .CHANNELS(C), .DIV(D)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ser_out(ser_out), .sclk(sclk), .latch(latch), .busy(busy)
    );

    piso_serializer #(.WIDTH(2), .CHANNELS(1), .DIV(1)) dut_c (
        .clk(clk), .reset(reset), .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .ser_out(c_ser_out), .sclk(c_sclk), .latch(c_latch), .busy(c_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic compare_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Frame-timeline model: each frame occupies P cycles from its load edge.
    logic           m_active = 1'b0;
    int             m_k = 0;
    logic [C*W-1:0] m_cur = '0;
    logic [C*W-1:0] m_shadow = '0;
    logic           m_full = 1'b0;
    logic           m_ready = 1'b0;

    always @(posedge clk) begin
        logic xfer;
        if (reset) begin
            m_active = 1'b0;
            m_full   = 1'b0;
            m_ready  = 1'b0;
            m_k      = 0;
        end else begin
            xfer = in_valid && m_ready;
            if (m_active) begin
                m_k++;
                if (m_k == P) m_active = 1'b0;
            end
            if (!m_active && m_full) begin
                m_active = 1'b1;
                m_k      = 0;
                m_cur    = m_shadow;
                m_full   = 1'b0;
            end
            if (xfer) begin
                m_shadow = in_data;
                m_full   = 1'b1;
            end
            m_ready = !m_full;
        end
    end

    always @(negedge clk) begin
        logic         e_sclk, e_latch, e_busy;
        logic [C-1:0] e_ser;
        int           b;
        if (compare_en) begin
            e_sclk = 1'b0; e_latch = 1'b0; e_busy = 1'b0; e_ser = '0;
            if (m_active) begin
                e_busy = 1'b1;
                if (m_k < 2*W*D) begin
                    b = m_k / (2*D);
                    e_sclk = (m_k % (2*D)) >= D;
                    for (int c = 0; c < C; c++) begin
`ifdef PISO_SERIALIZER_LSB_FIRST_EN
                        e_ser[c] = m_cur[c*W + b];
`else
                        e_ser[c] = m_cur[c*W + W-1-b];
`endif
                    end
                end else begin
                    e_latch = 1'b1;
                end
            end
            check("model_in_ready", in_ready, m_ready);
            check("model_sclk", sclk, e_sclk);
            check("model_latch", latch, e_latch);
            check("model_busy", busy, e_busy);
            check("model_ser_out", ser_out, e_ser);
        end
    end

    // Event recorder for the literal checks.
    logic prev_sclk = 1'b0, prev_latch = 1'b0, prev_busy = 1'b0, prev_c_latch = 1'b0;
    logic rise0[$], rise1[$];
    int   latch_rise[$], latch_fall[$], busy_rise[$], busy_fall[$], c_latch_rise[$];

    always @(negedge clk) begin
        if (compare_en) begin
            if (sclk && !prev_sclk) begin
                rise0.push_back(ser_out[0]);
                rise1.push_back(ser_out[1]);
            end
            if (latch && !prev_latch) latch_rise.push_back(cyc);
            if (!latch && prev_latch) latch_fall.push_back(cyc);
            if (busy && !prev_busy) busy_rise.push_back(cyc);
            if (!busy && prev_busy) busy_fall.push_back(cyc);
            if (c_latch && !prev_c_latch) c_latch_rise.push_back(cyc);
            prev_sclk = sclk; prev_latch = latch; prev_busy = busy; prev_c_latch = c_latch;
        end
    end

    task automatic clear_events();
        rise0.delete(); rise1.delete();
        latch_rise.delete(); latch_fall.delete();
        busy_rise.delete(); busy_fall.delete(); c_latch_rise.delete();
    endtask

    task automatic send(input logic [C*W-1:0] d, output int t, output logic busy_at);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_accepted", n < 200, 1);
        busy_at = busy;
        @(negedge clk);
        t = cyc;
    endtask

    task automatic c_send(input logic [1:0] d);
        int n = 0;
        c_in_data  = d;
        c_in_valid = 1'b1;
        while (c_in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("c_send_accepted", n < 200, 1);
        @(negedge clk);
    endtask

    function automatic logic [7:0] seq8(input int lane, input int base);
        logic [7:0] s = '0;
        for (int i = 0; i < 8; i++) s = {s[6:0], (lane == 0) ? rise0[base+i] : rise1[base+i]};
        return s;
    endfunction

    task automatic wait_falls(input int n);
        for (int i = 0; i < 400 && latch_fall.size() < n; i++) @(negedge clk);
        check("latch_fall_seen", latch_fall.size() >= n, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int   t0, t1, t2, t3;
        logic b0, b1, b2, b3;
        logic [4:0] v_sclk, v_latch, v_ser;

        @(negedge clk);
        compare_en = 1'b1;
        check("reset_sclk", sclk, 0);
        check("reset_latch", latch, 0);
        check("reset_busy", busy, 0);
        check("reset_ser_out", ser_out, 0);
        check("reset_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1);

        // Single frame: lane0=0xA5, lane1=0x3C.
        clear_events();
        send({8'h3C, 8'hA5}, t0, b0);
        in_valid = 1'b0;
        wait_falls(1);
        check("single_sclk_rises", rise0.size(), 8);
        check("single_lane0_bits", seq8(0, 0), 8'hA5);
        check("single_lane1_bits", seq8(1, 0), 8'h3C);
        check("single_latency", latch_fall[0] - t0, 35);
        check("single_latch_len", latch_fall[0] - latch_rise[0], 2);

        // Back-to-back with backpressure on a third frame.
        clear_events();
        send({8'h00, 8'hFF}, t1, b1);
        send({8'h80, 8'h01}, t2, b2);
        send({8'h0F, 8'h96}, t3, b3);
        in_valid = 1'b0;
        wait_falls(3);
        check("b2b_second_during_busy", b2, 1);
        check("b2b_period_1", latch_rise[1] - latch_rise[0], 34);
        check("b2b_period_2", latch_rise[2] - latch_rise[1], 34);
        check("b2b_single_busy_fall", busy_fall.size(), 1);
        check("backpressure_release", t3 - latch_fall[0], 1);
        check("b2b_sclk_rises", rise0.size(), 24);
        check("b2b_f1_lane0", seq8(0, 0), 8'hFF);
        check("b2b_f1_lane1", seq8(1, 0), 8'h00);
`ifdef PISO_SERIALIZER_LSB_FIRST_EN
        check("b2b_f2_lane0", seq8(0, 8), 8'h80);
        check("b2b_f2_lane1", seq8(1, 8), 8'h01);
        check("b2b_f3_lane0", seq8(0, 16), 8'h69);
        check("b2b_f3_lane1", seq8(1, 16), 8'hF0);
`else
        check("b2b_f2_lane0", seq8(0, 8), 8'h01);
        check("b2b_f2_lane1", seq8(1, 8), 8'h80);
        check("b2b_f3_lane0", seq8(0, 16), 8'h96);
        check("b2b_f3_lane1", seq8(1, 16), 8'h0F);
`endif

        // Bit order: lane0=0x01.
        clear_events();
        send({8'h00, 8'h01}, t0, b0);
        in_valid = 1'b0;
        wait_falls(1);
`ifdef PISO_SERIALIZER_LSB_FIRST_EN
        check("order_lane0", seq8(0, 0), 8'b1000_0000);
`else
        check("order_lane0", seq8(0, 0), 8'b0000_0001);
`endif

        // Reset mid-SHIFT with a second frame waiting in the shadow.
        send({8'h12, 8'h34}, t0, b0);
        send({8'h56, 8'h78}, t1, b1);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        clear_events();
        @(negedge clk);
        check("abort_sclk", sclk, 0);
        check("abort_latch", latch, 0);
        check("abort_busy", busy, 0);
        check("abort_ser_out", ser_out, 0);
        check("abort_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_in_ready_release", in_ready, 1);
        repeat (60) @(negedge clk);
        check("abort_no_latch", latch_rise.size(), 0);
        check("abort_shadow_discarded", busy_rise.size(), 0);

        // DIV=1, WIDTH=2 corner on the second instance.
        c_send(2'b10);
        c_in_valid = 1'b0;
        v_sclk = '0; v_latch = '0; v_ser = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            v_sclk  = {v_sclk[3:0], c_sclk};
            v_latch = {v_latch[3:0], c_latch};
            v_ser   = {v_ser[3:0], c_ser_out[0]};
        end
        check("corner_sclk", v_sclk, 5'b01010);
        check("corner_latch", v_latch, 5'b00001);
`ifdef PISO_SERIALIZER_LSB_FIRST_EN
        check("corner_ser", v_ser, 5'b00110);
`else
        check("corner_ser", v_ser, 5'b11000);
`endif
        @(negedge clk);
        check("corner_latch_end", c_latch, 0);
        check("corner_busy_end", c_busy, 0);
        clear_events();
        c_send(2'b10);
        c_send(2'b01);
        c_in_valid = 1'b0;
        for (int i = 0; i < 100 && c_latch_rise.size() < 2; i++) @(negedge clk);
        check("corner_two_latches", c_latch_rise.size(), 2);
        check("corner_period", c_latch_rise[1] - c_latch_rise[0], 5);
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
